// File: rtl/hazard_unit_np.sv
// N-stage pipeline hazard control: per-stage stall/flush, PC enable and next-PC select,
// plus a trap/halt sequencer that drains in-flight data-memory accesses before redirecting.
module hazard_unit_np #(
  parameter int NUM_STAGES    = 3,
  parameter int MEM_STAGE     = NUM_STAGES - 1,
  parameter int RESOLVE_STAGE = NUM_STAGES - 1,
  parameter int COUNT_W       = 32
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  i_ram_busy,
  input  logic                  iren,
  input  logic                  d_ram_busy,
  input  logic                  dren,
  input  logic                  dwen,
  input  logic                  mispredict,
  input  logic                  jump,
  input  logic                  ex_excptn,
  input  logic                  interrupt,
  input  logic                  ret,
  input  logic                  halt,
  input  logic [NUM_STAGES-1:0] stage_valid,
  output logic                  pc_en,
  output logic [1:0]            npc_sel,
  output logic [NUM_STAGES-1:0] stall,
  output logic [NUM_STAGES-1:0] flush,
  output logic                  insert_pc,
  output logic                  pipeline_finish,
  output logic [COUNT_W-1:0]    stall_cnt,
  output logic [COUNT_W-1:0]    redirect_cnt
);

  function automatic logic [NUM_STAGES-1:0] low_mask(input int hi);
    logic [NUM_STAGES-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_STAGES; i++) m[i] = (i <= hi);
    return m;
  endfunction

  localparam logic [NUM_STAGES-1:0] ALL_ONES  = '1;
  localparam logic [NUM_STAGES-1:0] MEM_MASK  = low_mask(MEM_STAGE);
  localparam logic [NUM_STAGES-1:0] BELOW_MEM = low_mask(MEM_STAGE - 1);
  localparam logic [NUM_STAGES-1:0] ABOVE_MEM = ~low_mask(MEM_STAGE);
  localparam logic [NUM_STAGES-1:0] RES_MASK  = low_mask(RESOLVE_STAGE);
  localparam logic [NUM_STAGES-1:0] BELOW_RES = low_mask(RESOLVE_STAGE - 1);
  localparam logic [NUM_STAGES-1:0] ABOVE_RES = ~low_mask(RESOLVE_STAGE);
  localparam logic [NUM_STAGES-1:0] STAGE0    = low_mask(0);
  localparam logic [NUM_STAGES-1:0] STAGE1    = low_mask(1) & ~low_mask(0);
  localparam logic [NUM_STAGES-1:0] HD_STALL  = low_mask(MEM_STAGE) & ~low_mask(0);
  localparam bit                    RES_BEHIND_MEM = (RESOLVE_STAGE <= MEM_STAGE);

  typedef enum logic [2:0] {
    S_RUN        = 3'd0,
    S_DRAIN      = 3'd1,
    S_TRAP       = 3'd2,
    S_HALT_DRAIN = 3'd3,
    S_HALTED     = 3'd4
  } state_t;

  state_t state, next_state;
  logic   trap_seen;
  logic   dmem_wait, imem_wait, trap_req, branch, halt_clear;
  logic   stall_inc, redirect_inc;
  logic   unused_top_valid;

  // Memory handshake: a request completes on a cycle where it is asserted and its busy
  // is low; busy never cancels a request, it only holds the requesting stage.
  assign dmem_wait        = d_ram_busy & (dren | dwen);
  assign imem_wait        = i_ram_busy & iren;
  assign trap_req         = ex_excptn | interrupt;
  assign branch           = mispredict | jump;
  assign halt_clear       = (stage_valid[NUM_STAGES-2:0] == '0) && !dmem_wait;
  assign unused_top_valid = stage_valid[NUM_STAGES-1];

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state     <= S_RUN;
      trap_seen <= 1'b0;
    end else begin
      state     <= next_state;
      trap_seen <= (state == S_TRAP);
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_RUN: begin
        if (trap_req)                   next_state = dmem_wait ? S_DRAIN : S_TRAP;
        else if (!ret && !branch && halt) next_state = S_HALT_DRAIN;
      end
      S_DRAIN:      if (!d_ram_busy) next_state = S_TRAP;
      S_TRAP:       if (!i_ram_busy) next_state = S_RUN;
      S_HALT_DRAIN: if (halt_clear)  next_state = S_HALTED;
      S_HALTED:     next_state = S_HALTED;
      default:      next_state = S_RUN;
    endcase
  end

  always_comb begin
    pc_en           = 1'b0;
    npc_sel         = 2'b00;
    stall           = '0;
    flush           = '0;
    insert_pc       = 1'b0;
    pipeline_finish = 1'b0;
    redirect_inc    = 1'b0;
    if (!nRST) begin
      flush = ALL_ONES;
    end else begin
      case (state)
        S_RUN: begin
          if (trap_req) begin
            if (dmem_wait) begin
              stall = MEM_MASK;
              flush = ABOVE_MEM;
            end else begin
              flush = BELOW_MEM;
            end
          end else if (ret) begin
            if (dmem_wait) begin
              stall = MEM_MASK;
              flush = ABOVE_MEM;
            end else if (i_ram_busy) begin
              npc_sel = 2'b11;
              stall   = MEM_MASK;
              flush   = ABOVE_MEM;
            end else begin
              npc_sel      = 2'b11;
              flush        = ALL_ONES;
              pc_en        = 1'b1;
              redirect_inc = 1'b1;
            end
          end else if (branch) begin
            if (dmem_wait && RES_BEHIND_MEM) begin
              stall = MEM_MASK;
              flush = ABOVE_MEM;
            end else if (i_ram_busy) begin
              npc_sel = 2'b01;
              stall   = RES_MASK;
              flush   = ABOVE_RES;
            end else begin
              npc_sel      = 2'b01;
              flush        = BELOW_RES;
              pc_en        = 1'b1;
              redirect_inc = 1'b1;
            end
          end else if (halt) begin
            flush = STAGE0;
            stall = dmem_wait ? HD_STALL : '0;
          end else if (dmem_wait) begin
            stall = MEM_MASK;
            flush = ABOVE_MEM;
          end else if (imem_wait) begin
            stall = STAGE0;
            flush = STAGE1;
          end else begin
            pc_en = 1'b1;
          end
        end
        S_DRAIN: begin
          stall = MEM_MASK;
          flush = ABOVE_MEM;
        end
        S_TRAP: begin
          npc_sel      = 2'b10;
          flush        = ALL_ONES;
          pc_en        = !i_ram_busy;
          insert_pc    = !trap_seen;
          redirect_inc = !trap_seen;
        end
        // Older instructions keep flowing so the halt can retire behind them.
        S_HALT_DRAIN: begin
          flush = STAGE0;
          stall = dmem_wait ? HD_STALL : '0;
        end
        S_HALTED: begin
          stall           = ALL_ONES;
          pipeline_finish = 1'b1;
        end
        default: flush = ALL_ONES;
      endcase
    end
    stall_inc = nRST && (state == S_RUN) && !pc_en;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      stall_cnt    <= '0;
      redirect_cnt <= '0;
    end else begin
      if (stall_inc && (stall_cnt != {COUNT_W{1'b1}}))
        stall_cnt <= stall_cnt + COUNT_W'(1);
      if (redirect_inc && (redirect_cnt != {COUNT_W{1'b1}}))
        redirect_cnt <= redirect_cnt + COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_unit_np.sv
// Bench for hazard_unit_np (3 stages, 4-bit counters): scenario tasks plan stimulus and
// expected outputs into queues, replay them one cycle at a time and compare inline.
module tb_hazard_unit_np;

  logic       CLK, nRST;
  logic       i_ram_busy, iren, d_ram_busy, dren, dwen;
  logic       mispredict, jump, ex_excptn, interrupt, ret, halt;
  logic [2:0] stage_valid;
  logic       pc_en, insert_pc, pipeline_finish;
  logic [1:0] npc_sel;
  logic [2:0] stall, flush;
  logic [3:0] stall_cnt, redirect_cnt;

  hazard_unit_np #(.NUM_STAGES(3), .COUNT_W(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .i_ram_busy(i_ram_busy), .iren(iren), .d_ram_busy(d_ram_busy),
    .dren(dren), .dwen(dwen), .mispredict(mispredict), .jump(jump),
    .ex_excptn(ex_excptn), .interrupt(interrupt), .ret(ret), .halt(halt),
    .stage_valid(stage_valid), .pc_en(pc_en), .npc_sel(npc_sel),
    .stall(stall), .flush(flush), .insert_pc(insert_pc),
    .pipeline_finish(pipeline_finish), .stall_cnt(stall_cnt),
    .redirect_cnt(redirect_cnt)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [10:0] E_IBUSY = 11'h400, E_IREN = 11'h200, E_DBUSY = 11'h100;
  localparam logic [10:0] E_DREN  = 11'h080, E_DWEN = 11'h040, E_MISP  = 11'h020;
  localparam logic [10:0] E_JUMP  = 11'h010, E_EXC  = 11'h008, E_INT   = 11'h004;
  localparam logic [10:0] E_RET   = 11'h002, E_HALT = 11'h001;

  // expected vector: {pc_en, npc_sel, stall, flush, insert_pc, pipeline_finish}
  localparam logic [10:0] IDLE_X   = {1'b1, 2'b00, 3'b000, 3'b000, 1'b0, 1'b0};
  localparam logic [10:0] RST_X    = {1'b0, 2'b00, 3'b000, 3'b111, 1'b0, 1'b0};
  localparam logic [10:0] DSTALL_X = {1'b0, 2'b00, 3'b111, 3'b000, 1'b0, 1'b0};
  localparam logic [10:0] ISTALL_X = {1'b0, 2'b00, 3'b001, 3'b010, 1'b0, 1'b0};
  localparam logic [10:0] HDRAIN_X = {1'b0, 2'b00, 3'b000, 3'b001, 1'b0, 1'b0};
  localparam logic [10:0] HALTED_X = {1'b0, 2'b00, 3'b111, 3'b000, 1'b0, 1'b1};
  localparam logic [10:0] TREQ_X   = {1'b0, 2'b00, 3'b000, 3'b011, 1'b0, 1'b0};
  localparam logic [10:0] TRAP1_X  = {1'b1, 2'b10, 3'b000, 3'b111, 1'b1, 1'b0};
  localparam logic [10:0] BR_X     = {1'b1, 2'b01, 3'b000, 3'b011, 1'b0, 1'b0};
  localparam logic [10:0] BRWAIT_X = {1'b0, 2'b01, 3'b111, 3'b000, 1'b0, 1'b0};
  localparam logic [10:0] RET_X    = {1'b1, 2'b11, 3'b000, 3'b111, 1'b0, 1'b0};
  localparam logic [10:0] RETWT_X  = {1'b0, 2'b11, 3'b111, 3'b000, 1'b0, 1'b0};

  logic [14:0] stim_q[$];
  logic [10:0] exp_q[$];
  logic [10:0] obs, got, want;
  int          n_cmp, n_bad;

  assign obs = {pc_en, npc_sel, stall, flush, insert_pc, pipeline_finish};

  // driver tasks
  task automatic plan(input logic rst, input logic [10:0] ev, input logic [2:0] sv,
                      input logic [10:0] expv);
    stim_q.push_back({rst, ev, sv});
    exp_q.push_back(expv);
  endtask

  task automatic apply_next();
    logic [14:0] s;
    @(negedge CLK);
    s = stim_q.pop_front();
    nRST = !s[14];
    {i_ram_busy, iren, d_ram_busy, dren, dwen, mispredict, jump,
     ex_excptn, interrupt, ret, halt} = s[13:3];
    stage_valid = s[2:0];
    #1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST = 1'b0;
    {i_ram_busy, iren, d_ram_busy, dren, dwen, mispredict, jump,
     ex_excptn, interrupt, ret, halt} = '0;
    stage_valid = '0;
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    int k = 0;
    plan(1'b1, '0, 3'b000, RST_X);
    plan(1'b1, '0, 3'b111, RST_X);
    plan(1'b0, '0, 3'b000, IDLE_X);
    plan(1'b0, '0, 3'b000, IDLE_X);
    while (stim_q.size() != 0) begin
      apply_next();
      got = obs; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL reset step %0d: got %b want %b", k, got, want);
      end
      k++;
    end
    n_cmp++; if (stall_cnt !== 4'd0) begin n_bad++; $display("FAIL reset stall_cnt: got %0d want 0", stall_cnt); end
    n_cmp++; if (redirect_cnt !== 4'd0) begin n_bad++; $display("FAIL reset redirect_cnt: got %0d want 0", redirect_cnt); end
  endtask

  task automatic test_dmem_wait();
    int k = 0;
    do_reset();
    plan(1'b0, E_DBUSY, 3'b000, IDLE_X);
    plan(1'b0, E_DREN | E_DBUSY, 3'b000, DSTALL_X);
    plan(1'b0, E_DREN | E_DBUSY, 3'b000, DSTALL_X);
    plan(1'b0, E_DWEN | E_DBUSY, 3'b000, DSTALL_X);
    plan(1'b0, E_DREN | E_DWEN | E_DBUSY, 3'b000, DSTALL_X);
    plan(1'b0, E_DREN, 3'b000, IDLE_X);
    plan(1'b0, '0, 3'b000, IDLE_X);
    while (stim_q.size() != 0) begin
      apply_next();
      got = obs; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL dmem_wait step %0d: got %b want %b", k, got, want);
      end
      k++;
    end
    n_cmp++; if (stall_cnt !== 4'd4) begin n_bad++; $display("FAIL dmem_wait stall_cnt: got %0d want 4", stall_cnt); end
    n_cmp++; if (redirect_cnt !== 4'd0) begin n_bad++; $display("FAIL dmem_wait redirect_cnt: got %0d want 0", redirect_cnt); end
  endtask

  task automatic test_imem_wait();
    int k = 0;
    do_reset();
    plan(1'b0, E_IBUSY, 3'b000, IDLE_X);
    plan(1'b0, E_IREN, 3'b000, IDLE_X);
    plan(1'b0, E_IREN | E_IBUSY, 3'b111, ISTALL_X);
    plan(1'b0, E_IREN | E_IBUSY, 3'b000, ISTALL_X);
    plan(1'b0, '0, 3'b000, IDLE_X);
    while (stim_q.size() != 0) begin
      apply_next();
      got = obs; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL imem_wait step %0d: got %b want %b", k, got, want);
      end
      k++;
    end
    n_cmp++; if (stall_cnt !== 4'd2) begin n_bad++; $display("FAIL imem_wait stall_cnt: got %0d want 2", stall_cnt); end
  endtask

  task automatic test_mispredict();
    int k = 0;
    do_reset();
    plan(1'b0, E_MISP | E_IBUSY | E_IREN, 3'b000, BRWAIT_X);
    plan(1'b0, E_MISP | E_IBUSY | E_IREN, 3'b000, BRWAIT_X);
    plan(1'b0, E_MISP, 3'b000, BR_X);
    plan(1'b0, '0, 3'b000, IDLE_X);
    plan(1'b0, E_JUMP | E_IBUSY, 3'b000, BRWAIT_X);
    plan(1'b0, E_JUMP, 3'b000, BR_X);
    plan(1'b0, E_JUMP, 3'b000, BR_X);
    plan(1'b0, E_MISP | E_DREN | E_DBUSY, 3'b000, DSTALL_X);
    plan(1'b0, '0, 3'b000, IDLE_X);
    while (stim_q.size() != 0) begin
      apply_next();
      got = obs; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL mispredict step %0d: got %b want %b", k, got, want);
      end
      k++;
    end
    n_cmp++; if (redirect_cnt !== 4'd3) begin n_bad++; $display("FAIL mispredict redirect_cnt: got %0d want 3", redirect_cnt); end
    n_cmp++; if (stall_cnt !== 4'd4) begin n_bad++; $display("FAIL mispredict stall_cnt: got %0d want 4", stall_cnt); end
  endtask

  task automatic test_ret();
    int k = 0;
    do_reset();
    plan(1'b0, E_RET | E_IBUSY, 3'b000, RETWT_X);
    plan(1'b0, E_RET, 3'b000, RET_X);
    plan(1'b0, E_RET | E_DWEN | E_DBUSY, 3'b000, DSTALL_X);
    plan(1'b0, E_RET | E_MISP, 3'b000, RET_X);
    plan(1'b0, '0, 3'b000, IDLE_X);
    while (stim_q.size() != 0) begin
      apply_next();
      got = obs; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL ret step %0d: got %b want %b", k, got, want);
      end
      k++;
    end
    n_cmp++; if (redirect_cnt !== 4'd2) begin n_bad++; $display("FAIL ret redirect_cnt: got %0d want 2", redirect_cnt); end
    n_cmp++; if (stall_cnt !== 4'd2) begin n_bad++; $display("FAIL ret stall_cnt: got %0d want 2", stall_cnt); end
  endtask

  task automatic test_trap_drain();
    int k = 0;
    do_reset();
    plan(1'b0, E_EXC | E_DWEN | E_DBUSY, 3'b111, DSTALL_X);
    plan(1'b0, E_EXC | E_DWEN | E_DBUSY, 3'b111, DSTALL_X);
    plan(1'b0, E_EXC | E_DWEN | E_DBUSY, 3'b111, DSTALL_X);
    plan(1'b0, E_DWEN, 3'b111, DSTALL_X);
    plan(1'b0, '0, 3'b000, TRAP1_X);
    plan(1'b0, '0, 3'b000, IDLE_X);
    plan(1'b0, '0, 3'b000, IDLE_X);
    while (stim_q.size() != 0) begin
      apply_next();
      got = obs; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL trap_drain step %0d: got %b want %b", k, got, want);
      end
      k++;
    end
    n_cmp++; if (redirect_cnt !== 4'd1) begin n_bad++; $display("FAIL trap_drain redirect_cnt: got %0d want 1", redirect_cnt); end
    n_cmp++; if (stall_cnt !== 4'd1) begin n_bad++; $display("FAIL trap_drain stall_cnt: got %0d want 1", stall_cnt); end
  endtask

  task automatic test_interrupt_trap();
    int k = 0;
    do_reset();
    plan(1'b0, E_INT, 3'b000, TREQ_X);
    plan(1'b0, E_INT | E_IBUSY, 3'b000, {1'b0, 2'b10, 3'b000, 3'b111, 1'b1, 1'b0});
    plan(1'b0, E_INT | E_IBUSY, 3'b000, {1'b0, 2'b10, 3'b000, 3'b111, 1'b0, 1'b0});
    plan(1'b0, E_INT, 3'b000, {1'b1, 2'b10, 3'b000, 3'b111, 1'b0, 1'b0});
    plan(1'b0, E_INT, 3'b000, TREQ_X);
    plan(1'b0, '0, 3'b000, TRAP1_X);
    plan(1'b0, '0, 3'b000, IDLE_X);
    while (stim_q.size() != 0) begin
      apply_next();
      got = obs; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL interrupt_trap step %0d: got %b want %b", k, got, want);
      end
      k++;
    end
    n_cmp++; if (redirect_cnt !== 4'd2) begin n_bad++; $display("FAIL interrupt_trap redirect_cnt: got %0d want 2", redirect_cnt); end
    n_cmp++; if (stall_cnt !== 4'd2) begin n_bad++; $display("FAIL interrupt_trap stall_cnt: got %0d want 2", stall_cnt); end
  endtask

  task automatic test_priority();
    int k = 0;
    do_reset();
    plan(1'b0, E_EXC | E_INT | E_MISP, 3'b111, TREQ_X);
    plan(1'b0, '0, 3'b000, TRAP1_X);
    plan(1'b0, '0, 3'b000, IDLE_X);
    plan(1'b0, '0, 3'b000, IDLE_X);
    while (stim_q.size() != 0) begin
      apply_next();
      got = obs; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL priority step %0d: got %b want %b", k, got, want);
      end
      k++;
    end
    n_cmp++; if (redirect_cnt !== 4'd1) begin n_bad++; $display("FAIL priority redirect_cnt: got %0d want 1", redirect_cnt); end
  endtask

  task automatic test_reset_abort();
    int k = 0;
    do_reset();
    plan(1'b0, E_EXC | E_DWEN | E_DBUSY, 3'b000, DSTALL_X);
    plan(1'b0, E_DBUSY, 3'b000, DSTALL_X);
    plan(1'b1, E_DBUSY, 3'b000, RST_X);
    plan(1'b0, '0, 3'b000, IDLE_X);
    plan(1'b0, '0, 3'b000, IDLE_X);
    while (stim_q.size() != 0) begin
      apply_next();
      got = obs; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL reset_abort step %0d: got %b want %b", k, got, want);
      end
      k++;
    end
    n_cmp++; if (redirect_cnt !== 4'd0) begin n_bad++; $display("FAIL reset_abort redirect_cnt: got %0d want 0", redirect_cnt); end
  endtask

  task automatic test_halt();
    int k = 0;
    do_reset();
    plan(1'b0, E_HALT, 3'b011, HDRAIN_X);
    plan(1'b0, E_EXC | E_INT, 3'b001, HDRAIN_X);
    plan(1'b0, E_INT, 3'b000, HDRAIN_X);
    plan(1'b0, E_INT, 3'b000, HALTED_X);
    plan(1'b0, E_INT | E_EXC, 3'b000, HALTED_X);
    plan(1'b0, '0, 3'b100, HALTED_X);
    plan(1'b0, E_MISP | E_RET, 3'b000, HALTED_X);
    while (stim_q.size() != 0) begin
      apply_next();
      got = obs; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL halt step %0d: got %b want %b", k, got, want);
      end
      k++;
    end
    n_cmp++; if (stall_cnt !== 4'd1) begin n_bad++; $display("FAIL halt stall_cnt: got %0d want 1", stall_cnt); end
    n_cmp++; if (redirect_cnt !== 4'd0) begin n_bad++; $display("FAIL halt redirect_cnt: got %0d want 0", redirect_cnt); end
  endtask

  // continues from the HALTED state left by test_halt
  task automatic test_halt_release();
    int k = 0;
    plan(1'b0, E_INT, 3'b000, HALTED_X);
    plan(1'b1, E_INT, 3'b000, RST_X);
    plan(1'b0, '0, 3'b000, IDLE_X);
    plan(1'b0, '0, 3'b000, IDLE_X);
    while (stim_q.size() != 0) begin
      apply_next();
      got = obs; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL halt_release step %0d: got %b want %b", k, got, want);
      end
      k++;
    end
    n_cmp++; if (stall_cnt !== 4'd0) begin n_bad++; $display("FAIL halt_release stall_cnt: got %0d want 0", stall_cnt); end
  endtask

  task automatic test_back_to_back();
    int          k = 0;
    int          sc = 0;
    int          rc = 0;
    logic [10:0] ev, xv;
    do_reset();
    for (int c = 0; c < 40; c++) begin
      case ($urandom_range(0, 4))
        1: begin ev = E_DREN | E_DBUSY;          xv = DSTALL_X; if (sc < 15) sc++; end
        2: begin ev = E_IREN | E_IBUSY;          xv = ISTALL_X; if (sc < 15) sc++; end
        3: begin ev = E_MISP;                    xv = BR_X;     if (rc < 15) rc++; end
        4: begin ev = E_JUMP | E_IREN | E_IBUSY; xv = BRWAIT_X; if (sc < 15) sc++; end
        default: begin ev = '0;                  xv = IDLE_X; end
      endcase
      plan(1'b0, ev, 3'($urandom_range(0, 7)), xv);
    end
    plan(1'b0, '0, 3'b000, IDLE_X);
    while (stim_q.size() != 0) begin
      apply_next();
      got = obs; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL back_to_back step %0d: got %b want %b", k, got, want);
      end
      k++;
    end
    n_cmp++; if (stall_cnt !== 4'(sc)) begin n_bad++; $display("FAIL back_to_back stall_cnt: got %0d want %0d", stall_cnt, sc); end
    n_cmp++; if (redirect_cnt !== 4'(rc)) begin n_bad++; $display("FAIL back_to_back redirect_cnt: got %0d want %0d", redirect_cnt, rc); end
  endtask

  task automatic test_saturation();
    int k = 0;
    do_reset();
    for (int c = 0; c < 20; c++) plan(1'b0, E_DREN | E_DBUSY, 3'b000, DSTALL_X);
    for (int c = 0; c < 18; c++) plan(1'b0, E_JUMP, 3'b000, BR_X);
    plan(1'b0, '0, 3'b000, IDLE_X);
    while (stim_q.size() != 0) begin
      apply_next();
      got = obs; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL saturation step %0d: got %b want %b", k, got, want);
      end
      k++;
    end
    n_cmp++; if (stall_cnt !== 4'd15) begin n_bad++; $display("FAIL saturation stall_cnt: got %0d want 15", stall_cnt); end
    n_cmp++; if (redirect_cnt !== 4'd15) begin n_bad++; $display("FAIL saturation redirect_cnt: got %0d want 15", redirect_cnt); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    nRST  = 1'b0;
    {i_ram_busy, iren, d_ram_busy, dren, dwen, mispredict, jump,
     ex_excptn, interrupt, ret, halt} = '0;
    stage_valid = '0;
    test_reset();
    test_dmem_wait();
    test_imem_wait();
    test_mispredict();
    test_ret();
    test_trap_drain();
    test_interrupt_trap();
    test_priority();
    test_reset_abort();
    test_halt();
    test_halt_release();
    test_back_to_back();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
